ubit_decoder: RTL and testbench

- Unary-to-binary back end for the stochastic datapath; the inverse of the Sobol-RNG/comparator encoder.
- Counts the '1' bits of an incoming unary bitstream over a fixed window of 2^BITWIDTH accepted bits.
- Presents the count as a BITWIDTH-bit binary result through a one-entry valid/ready output register.
- Sits at the output of the uMUL array, one instance per product stream.

---
 rtl/ubit_decoder_if.sv | 25 ++
 rtl/ubit_decoder.sv | 101 ++++++++++
 tb/tb_ubit_decoder.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/ubit_decoder_if.sv
// Stream-in / result-out bundle for the unary decoder.
// The producer/consumer side uses master; the decoder uses slave.
interface ubit_decoder_if #(
  parameter int BITWIDTH = 8
);
  logic                iEn;
  logic                iClr;
  logic                iBit;
  logic                iReady;
  logic [BITWIDTH-1:0] oData;
  logic                oValid;
  logic                oSat;
  logic                oOvf;
  logic                oBusy;

  modport master (
    output iEn, iClr, iBit, iReady,
    input  oData, oValid, oSat, oOvf, oBusy
  );

  modport slave (
    input  iEn, iClr, iBit, iReady,
    output oData, oValid, oSat, oOvf, oBusy
  );
endinterface

// File: rtl/ubit_decoder.sv
// Counts ones over a window of 2^BITWIDTH accepted unary bits and presents the
// saturated count through a one-entry valid/ready output register.
module ubit_decoder #(
  parameter int BITWIDTH = 8
) (
  input  logic          iClk,
  input  logic          iRst,
  ubit_decoder_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t              stateReg, stateNext;
  logic [BITWIDTH-1:0] wCntReg, wCntNext;
  logic [BITWIDTH:0]   accReg, accNext;
  logic [BITWIDTH-1:0] dataReg, dataNext;
  logic                validReg, validNext;
  logic                satReg, satNext;
  logic                ovfReg, ovfNext;

  logic                accept;
  logic                complete;
  logic                transfer;
  logic [BITWIDTH:0]   total;

  always_comb begin
    accept   = bus.iEn && !bus.iClr;
    complete = accept && (wCntReg == {BITWIDTH{1'b1}});
    transfer = validReg && bus.iReady;
    total    = accReg + {{BITWIDTH{1'b0}}, bus.iBit};
  end

  always_comb begin
    stateNext = stateReg;
    wCntNext  = wCntReg;
    accNext   = accReg;
    dataNext  = dataReg;
    validNext = validReg;
    satNext   = satReg;
    ovfNext   = ovfReg;

    if (bus.iClr) begin
      // Abort drops the pending result but keeps the last data/sat visible.
      stateNext = IDLE;
      wCntNext  = '0;
      accNext   = '0;
      validNext = 1'b0;
      ovfNext   = 1'b0;
    end else if (complete) begin
      stateNext = IDLE;
      wCntNext  = '0;
      accNext   = '0;
      dataNext  = total[BITWIDTH] ? {BITWIDTH{1'b1}} : total[BITWIDTH-1:0];
      satNext   = total[BITWIDTH];
      validNext = 1'b1;
      // A same-cycle transfer consumes the old result, so only a stalled one is lost.
      if (validReg && !bus.iReady) begin
        ovfNext = 1'b1;
      end
    end else begin
      if (accept) begin
        stateNext = ACCUM;
        wCntNext  = wCntReg + BITWIDTH'(1);
        accNext   = total;
      end
      if (transfer) begin
        validNext = 1'b0;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      stateReg <= IDLE;
      wCntReg  <= '0;
      accReg   <= '0;
      dataReg  <= '0;
      validReg <= 1'b0;
      satReg   <= 1'b0;
      ovfReg   <= 1'b0;
    end else begin
      stateReg <= stateNext;
      wCntReg  <= wCntNext;
      accReg   <= accNext;
      dataReg  <= dataNext;
      validReg <= validNext;
      satReg   <= satNext;
      ovfReg   <= ovfNext;
    end
  end

  assign bus.oData  = dataReg;
  assign bus.oValid = validReg;
  assign bus.oSat   = satReg;
  assign bus.oOvf   = ovfReg;
  assign bus.oBusy  = (stateReg == ACCUM);

endmodule

// File: tb/tb_ubit_decoder.sv
// Randomised and directed bench for ubit_decoder; a window-level integer model
// predicts every output on every cycle, with literal checks pinning key results.
module tb_ubit_decoder;
  localparam int W = 8;
  localparam int N = 1 << W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   armed  = 1'b0;

  ubit_decoder_if #(.BITWIDTH(W)) bus ();

  ubit_decoder #(.BITWIDTH(W)) dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Model: count accepted bits and ones as plain integers per window.
  int   mAccepted = 0;
  int   mOnes     = 0;
  int   mData     = 0;
  bit   mValid    = 1'b0;
  bit   mSat      = 1'b0;
  bit   mOvf      = 1'b0;
  bit   mBusy     = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mAccepted = 0; mOnes = 0; mData = 0;
      mValid = 0; mSat = 0; mOvf = 0; mBusy = 0;
    end else if (bus.iClr) begin
      mAccepted = 0; mOnes = 0;
      mValid = 0; mOvf = 0; mBusy = 0;
    end else begin
      bit done;
      done = 1'b0;
      if (bus.iEn) begin
        mAccepted = mAccepted + 1;
        mOnes     = mOnes + int'(bus.iBit);
        if (mAccepted == N) done = 1'b1;
      end
      if (done) begin
        if (mValid && !bus.iReady) mOvf = 1'b1;
        mValid    = 1'b1;
        mData     = (mOnes > N - 1) ? N - 1 : mOnes;
        mSat      = (mOnes == N);
        mAccepted = 0;
        mOnes     = 0;
        mBusy     = 1'b0;
      end else begin
        if (mValid && bus.iReady) mValid = 1'b0;
        if (bus.iEn) mBusy = 1'b1;
      end
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      cmp("oData",  int'(bus.oData),  mData);
      cmp("oValid", int'(bus.oValid), int'(mValid));
      cmp("oSat",   int'(bus.oSat),   int'(mSat));
      cmp("oOvf",   int'(bus.oOvf),   int'(mOvf));
      cmp("oBusy",  int'(bus.oBusy),  int'(mBusy));
    end
  end

  task automatic step(input logic en, input logic b, input logic c);
    bus.iEn  = en;
    bus.iBit = b;
    bus.iClr = c;
    @(posedge clk);
    #1;
    $display("cyc en=%0b bit=%0b clr=%0b rdy=%0b -> data=%0d valid=%0b sat=%0b ovf=%0b busy=%0b",
             en, b, c, bus.iReady, bus.oData, bus.oValid, bus.oSat, bus.oOvf, bus.oBusy);
  endtask

  task automatic window_const(input logic b);
    for (int i = 0; i < N; i++) step(1'b1, b, 1'b0);
  endtask

  function automatic logic [W-1:0] sobol(input int i);
    logic [W-1:0] idx, g, r;
    idx = i[W-1:0];
    g   = idx ^ (idx >> 1);
    for (int k = 0; k < W; k++) r[k] = g[W-1-k];
    return r;
  endfunction

  task automatic sobol_window(input int v);
    int pulses;
    logic [W-1:0] vv;
    vv = v[W-1:0];
    pulses = 0;
    for (int i = 0; i < N; i++) begin
      step(1'b1, (vv > sobol(i)), 1'b0);
      if (bus.oValid) pulses++;
    end
    cmp("sobol_pulse", pulses, 1);
    cmp("sobol_data", int'(bus.oData), v);
    cmp("sobol_sat", int'(bus.oSat), 0);
    cmp("sobol_valid", int'(bus.oValid), 1);
  endtask

  initial begin
    int accepted;
    int completions;
    bus.iEn = 0; bus.iBit = 0; bus.iClr = 0; bus.iReady = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    armed = 1'b1;
    cmp("rst_data", int'(bus.oData), 0);
    cmp("rst_valid", int'(bus.oValid), 0);
    rst = 1'b0;

    // 128 ones then 128 zeros
    for (int i = 0; i < N; i++) step(1'b1, (i < N / 2), 1'b0);
    cmp("half_valid", int'(bus.oValid), 1);
    cmp("half_data", int'(bus.oData), 128);
    cmp("half_sat", int'(bus.oSat), 0);
    cmp("half_ovf", int'(bus.oOvf), 0);
    cmp("half_busy", int'(bus.oBusy), 0);

    bus.iReady = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    cmp("half_consumed", int'(bus.oValid), 0);

    sobol_window(77);
    sobol_window(0);
    sobol_window(255);

    window_const(1'b1);
    cmp("ones_data", int'(bus.oData), 255);
    cmp("ones_sat", int'(bus.oSat), 1);
    window_const(1'b0);
    cmp("zeros_data", int'(bus.oData), 0);
    cmp("zeros_sat", int'(bus.oSat), 0);

    // Two stalled completions -> overflow
    bus.iReady = 1'b0;
    window_const(1'b1);
    window_const(1'b1);
    cmp("ovf_set", int'(bus.oOvf), 1);
    cmp("ovf_valid", int'(bus.oValid), 1);
    bus.iReady = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    cmp("ovf_xfer_valid", int'(bus.oValid), 0);
    cmp("ovf_sticky", int'(bus.oOvf), 1);

    // Gapped window with iEn toggled randomly
    accepted = 0;
    completions = 0;
    for (int c = 0; c < 4 * N && accepted < N; c++) begin
      logic en;
      en = 1'($urandom_range(0, 1));
      step(en, 1'b1, 1'b0);
      if (en) accepted++;
      if (bus.oValid) completions++;
    end
    cmp("gap_accepted", accepted, N);
    cmp("gap_completions", completions, 1);
    cmp("gap_data", int'(bus.oData), 255);
    cmp("gap_ovf_kept", int'(bus.oOvf), 1);
    step(1'b0, 1'b0, 1'b0);

    // iClr on the completing bit
    for (int i = 0; i < N - 1; i++) step(1'b1, 1'b1, 1'b0);
    cmp("clr_pre_busy", int'(bus.oBusy), 1);
    step(1'b1, 1'b1, 1'b1);
    cmp("clr_valid", int'(bus.oValid), 0);
    cmp("clr_ovf", int'(bus.oOvf), 0);
    cmp("clr_data", int'(bus.oData), 255);
    cmp("clr_busy", int'(bus.oBusy), 0);
    for (int i = 0; i < N; i++) step(1'b1, (i < 10), 1'b0);
    cmp("clr_next_data", int'(bus.oData), 10);
    cmp("clr_next_valid", int'(bus.oValid), 1);

    // Reset mid-window
    for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    cmp("mid_rst_data", int'(bus.oData), 0);
    cmp("mid_rst_busy", int'(bus.oBusy), 0);
    cmp("mid_rst_valid", int'(bus.oValid), 0);

    // Random traffic, mostly dense bits, occasional clears and stalls
    for (int i = 0; i < 4000; i++) begin
      bus.iReady = 1'($urandom_range(0, 3) != 0);
      step(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 999) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
